// File: rtl/gpu_net_pkg.sv
// Shared constants and flit layout for the GPU node network interface.
package gpu_net_pkg;

   localparam int FLIT_W_DEF = 16;
   localparam int DEST_W_DEF = 6;
   localparam int PAY_W_DEF  = FLIT_W_DEF - DEST_W_DEF;
   localparam logic [DEST_W_DEF-1:0] BCAST_ID_DEF = {DEST_W_DEF{1'b1}};

   localparam int DEST_MSB = FLIT_W_DEF - 1;
   localparam int DEST_LSB = FLIT_W_DEF - DEST_W_DEF;
   localparam int PAY_MSB  = PAY_W_DEF - 1;
   localparam int PAY_LSB  = 0;

   typedef struct packed {
      logic [DEST_W_DEF-1:0] dest;
      logic [PAY_W_DEF-1:0]  payload;
   } flit_t;

endpackage

// File: rtl/gpu_net_fifo.sv
// Show-ahead FIFO: head is read straight from storage, no write-to-read bypass.
module gpu_net_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Zero when empty so a flushed FIFO never shows stale storage.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gpu_net_iface.sv
// GPU node NoC interface: TX queue onto the link, destination-filtered RX queue, drop counter.
module gpu_net_iface
   import gpu_net_pkg::*;
#(
   parameter int GPU_ID     = 6,
   parameter int FLIT_W     = FLIT_W_DEF,
   parameter int DEST_W     = DEST_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter logic [DEST_W-1:0] BCAST_ID = {DEST_W{1'b1}},
   parameter int CNT_W      = 16,
   localparam int PAY_W     = FLIT_W - DEST_W
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [DEST_W-1:0] tx_dest_in,
   input  logic [PAY_W-1:0]  tx_payload_in,
   input  logic              tx_valid_in,
   output logic              tx_ready_out,
   output logic [FLIT_W-1:0] net_data_out,
   output logic              net_valid_out,
   input  logic              net_ready_in,
   input  logic [FLIT_W-1:0] net_data_in,
   input  logic              net_valid_in,
   output logic              net_ready_out,
   output logic [PAY_W-1:0]  rx_payload_out,
   output logic              rx_bcast_out,
   output logic              rx_valid_out,
   input  logic              rx_ready_in,
   output logic [CNT_W-1:0]  drop_cnt
);

   logic              tx_full, tx_empty, tx_push, tx_pop;
   logic              rx_full, rx_empty, rx_push, rx_pop;
   logic              rx_accept, rx_drop, is_bcast, is_mine;
   logic [DEST_W-1:0] rx_dest;
   logic [PAY_W:0]    rx_din, rx_dout;

   assign tx_ready_out  = !tx_full;
   assign net_valid_out = !tx_empty;
   assign tx_push       = tx_valid_in && tx_ready_out;
   assign tx_pop        = net_valid_out && net_ready_in;

   gpu_net_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .push   (tx_push),
      .pop    (tx_pop),
      .din    ({tx_dest_in, tx_payload_in}),
      .dout   (net_data_out),
      .full   (tx_full),
      .empty  (tx_empty)
   );

   // Ready comes from the RX full flag only, so a full queue stalls every flit, matching or not.
   assign net_ready_out = !rx_full;
   assign rx_accept     = net_valid_in && net_ready_out;
   assign rx_dest       = net_data_in[FLIT_W-1 -: DEST_W];
   assign is_bcast      = (rx_dest == BCAST_ID);
   assign is_mine       = (rx_dest == DEST_W'(GPU_ID)) || is_bcast;
   assign rx_push       = rx_accept && is_mine;
   assign rx_drop       = rx_accept && !is_mine;
   assign rx_din        = {net_data_in[PAY_W-1:0], is_bcast};
   assign rx_valid_out  = !rx_empty;
   assign rx_pop        = rx_valid_out && rx_ready_in;

   gpu_net_fifo #(.WIDTH(PAY_W+1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .push   (rx_push),
      .pop    (rx_pop),
      .din    (rx_din),
      .dout   (rx_dout),
      .full   (rx_full),
      .empty  (rx_empty)
   );

   assign rx_payload_out = rx_dout[PAY_W:1];
   assign rx_bcast_out   = rx_dout[0];

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         drop_cnt <= '0;
      end else if (rx_drop && (drop_cnt != {CNT_W{1'b1}})) begin
         drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gpu_net_iface.sv
// Self-checking bench for gpu_net_iface with queue-based scoreboards per direction.
module tb_gpu_net_iface;
   import gpu_net_pkg::*;

   localparam int FLIT_W = 16;
   localparam int DEST_W = 6;
   localparam int PAY_W  = 10;
   localparam int CNT_W  = 2;

   logic              ACLK = 1'b0;
   logic              ARESET = 1'b1;
   logic [DEST_W-1:0] tx_dest_in = '0;
   logic [PAY_W-1:0]  tx_payload_in = '0;
   logic              tx_valid_in = 1'b0;
   logic              tx_ready_out;
   logic [FLIT_W-1:0] net_data_out;
   logic              net_valid_out;
   logic              net_ready_in = 1'b0;
   logic [FLIT_W-1:0] net_data_in = '0;
   logic              net_valid_in = 1'b0;
   logic              net_ready_out;
   logic [PAY_W-1:0]  rx_payload_out;
   logic              rx_bcast_out;
   logic              rx_valid_out;
   logic              rx_ready_in = 1'b0;
   logic [CNT_W-1:0]  drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [FLIT_W-1:0] tx_q[$];
   logic [PAY_W:0]    rx_q[$];

   always #5 ACLK = ~ACLK;

   gpu_net_iface #(.GPU_ID(6), .FLIT_W(FLIT_W), .DEST_W(DEST_W), .FIFO_DEPTH(4),
                   .CNT_W(CNT_W)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .tx_dest_in(tx_dest_in), .tx_payload_in(tx_payload_in),
      .tx_valid_in(tx_valid_in), .tx_ready_out(tx_ready_out),
      .net_data_out(net_data_out), .net_valid_out(net_valid_out),
      .net_ready_in(net_ready_in), .net_data_in(net_data_in),
      .net_valid_in(net_valid_in), .net_ready_out(net_ready_out),
      .rx_payload_out(rx_payload_out), .rx_bcast_out(rx_bcast_out),
      .rx_valid_out(rx_valid_out), .rx_ready_in(rx_ready_in),
      .drop_cnt(drop_cnt)
   );

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      tx_valid_in = 1'b0; net_valid_in = 1'b0;
      net_ready_in = 1'b0; rx_ready_in = 1'b0;
      tx_q.delete(); rx_q.delete();
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
   endtask

   task automatic test_reset();
      logic [FLIT_W+PAY_W+6:0] got, exp;
      do_reset();
      got = {tx_ready_out, net_valid_out, net_ready_out, rx_valid_out, rx_bcast_out,
             net_data_out, rx_payload_out, drop_cnt};
      exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {FLIT_W{1'b0}}, {PAY_W{1'b0}}, {CNT_W{1'b0}}};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL reset_state: got %h required %h", got, exp);
      end
   endtask

   task automatic test_tx_single();
      flit_t f;
      f.dest = 6'd7; f.payload = 10'h123;
      tx_dest_in = f.dest; tx_payload_in = f.payload; tx_valid_in = 1'b1;
      net_ready_in = 1'b1;
      tx_q.push_back(16'h1D23);
      n_cmp++;
      if (net_valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL tx_no_bypass: valid got %b required 0", net_valid_out);
      end
      step();
      tx_valid_in = 1'b0;
      n_cmp++;
      if (net_valid_out !== 1'b1 || net_data_out !== tx_q[0] || FLIT_W'(f) !== tx_q[0]) begin
         n_bad++;
         $display("FAIL tx_single: valid %b data %h required 1 %h", net_valid_out, net_data_out, tx_q[0]);
      end
      void'(tx_q.pop_front());
      step();
      n_cmp++;
      if (net_valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL tx_valid_drop: got %b required 0", net_valid_out);
      end
      net_ready_in = 1'b0;
   endtask

   task automatic test_tx_full();
      int budget;
      logic [FLIT_W-1:0] f;
      net_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         f = FLIT_W'($urandom);
         tx_dest_in = f[FLIT_W-1 -: DEST_W]; tx_payload_in = f[PAY_W-1:0];
         tx_valid_in = 1'b1;
         n_cmp++;
         if (tx_ready_out !== (i < 4)) begin
            n_bad++;
            $display("FAIL tx_ready_fill%0d: got %b required %b", i, tx_ready_out, (i < 4));
         end
         if (i < 4) tx_q.push_back(f);
         step();
      end
      tx_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (net_valid_out !== 1'b1 || net_data_out !== tx_q[0]) begin
            n_bad++;
            $display("FAIL tx_stall_stable: valid %b data %h required 1 %h", net_valid_out, net_data_out, tx_q[0]);
         end
         step();
      end
      net_ready_in = 1'b1;
      budget = 20;
      while (tx_q.size() > 0 && budget > 0) begin
         if (net_valid_out) begin
            n_cmp++;
            if (net_data_out !== tx_q[0]) begin
               n_bad++;
               $display("FAIL tx_drain_order: got %h required %h", net_data_out, tx_q[0]);
            end
            void'(tx_q.pop_front());
         end
         step();
         budget--;
      end
      n_cmp++;
      if (tx_q.size() != 0 || net_valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL tx_drain_timeout: left %0d valid %b required 0 0", tx_q.size(), net_valid_out);
      end
      net_ready_in = 1'b0;
   endtask

   task automatic test_rx_filter();
      int budget;
      rx_ready_in = 1'b0;
      net_valid_in = 1'b1;
      net_data_in = 16'h1ABC; rx_q.push_back({10'h2BC, 1'b0});
      step();
      net_data_in = 16'hFC01; rx_q.push_back({10'h001, 1'b1});
      step();
      net_valid_in = 1'b0;
      rx_ready_in = 1'b1;
      budget = 10;
      while (rx_q.size() > 0 && budget > 0) begin
         if (rx_valid_out) begin
            n_cmp++;
            if ({rx_payload_out, rx_bcast_out} !== rx_q[0]) begin
               n_bad++;
               $display("FAIL rx_filter: got %h/%b required %h/%b", rx_payload_out, rx_bcast_out,
                        rx_q[0][PAY_W:1], rx_q[0][0]);
            end
            void'(rx_q.pop_front());
         end
         step();
         budget--;
      end
      n_cmp++;
      if (rx_q.size() != 0 || rx_valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL rx_filter_timeout: left %0d valid %b required 0 0", rx_q.size(), rx_valid_out);
      end
      rx_ready_in = 1'b0;
   endtask

   task automatic test_drop();
      logic [CNT_W-1:0] exp_cnt;
      exp_cnt = '0;
      rx_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         net_data_in = {6'd5, PAY_W'(i * 37)};
         net_valid_in = 1'b1;
         step();
         if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
         n_cmp++;
         if (drop_cnt !== exp_cnt || rx_valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_count%0d: cnt %0d rxv %b required %0d 0", i, drop_cnt, rx_valid_out, exp_cnt);
         end
      end
      net_valid_in = 1'b0;
   endtask

   task automatic test_backpressure();
      int budget;
      do_reset();
      rx_ready_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         net_data_in = {6'd6, PAY_W'(10'h100 + i)};
         net_valid_in = 1'b1;
         rx_q.push_back({PAY_W'(10'h100 + i), 1'b0});
         step();
      end
      net_data_in = {6'd5, 10'h3FF};
      n_cmp++;
      if (net_ready_out !== 1'b0) begin
         n_bad++;
         $display("FAIL rx_full_ready: got %b required 0", net_ready_out);
      end
      step(); step();
      n_cmp++;
      if (drop_cnt !== 2'd0) begin
         n_bad++;
         $display("FAIL rx_stalled_drop: got %0d required 0", drop_cnt);
      end
      rx_ready_in = 1'b1;
      n_cmp++;
      if (rx_valid_out !== 1'b1 || {rx_payload_out, rx_bcast_out} !== rx_q[0]) begin
         n_bad++;
         $display("FAIL rx_bp_head: got %b %h required 1 %h", rx_valid_out, rx_payload_out, rx_q[0][PAY_W:1]);
      end
      void'(rx_q.pop_front());
      step();
      rx_ready_in = 1'b0;
      n_cmp++;
      if (net_ready_out !== 1'b1) begin
         n_bad++;
         $display("FAIL rx_ready_after_pop: got %b required 1", net_ready_out);
      end
      step();
      net_valid_in = 1'b0;
      n_cmp++;
      if (drop_cnt !== 2'd1) begin
         n_bad++;
         $display("FAIL rx_late_drop: got %0d required 1", drop_cnt);
      end
      rx_ready_in = 1'b1;
      budget = 10;
      while (rx_q.size() > 0 && budget > 0) begin
         if (rx_valid_out) begin
            n_cmp++;
            if ({rx_payload_out, rx_bcast_out} !== rx_q[0]) begin
               n_bad++;
               $display("FAIL rx_bp_order: got %h required %h", rx_payload_out, rx_q[0][PAY_W:1]);
            end
            void'(rx_q.pop_front());
         end
         step();
         budget--;
      end
      n_cmp++;
      if (rx_q.size() != 0 || rx_valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL rx_bp_timeout: left %0d valid %b required 0 0", rx_q.size(), rx_valid_out);
      end
      rx_ready_in = 1'b0;
   endtask

   task automatic test_reset_mid();
      int budget;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         tx_dest_in = 6'd9; tx_payload_in = PAY_W'(i + 1); tx_valid_in = 1'b1;
         step();
      end
      tx_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         net_data_in = (i == 3) ? {6'd2, 10'h0AA} : {6'd6, PAY_W'(i + 5)};
         net_valid_in = 1'b1;
         step();
      end
      net_valid_in = 1'b0;
      n_cmp++;
      if (net_valid_out !== 1'b1 || rx_valid_out !== 1'b1 || drop_cnt !== 2'd1) begin
         n_bad++;
         $display("FAIL pre_reset_fill: txv %b rxv %b cnt %0d required 1 1 1", net_valid_out, rx_valid_out, drop_cnt);
      end
      #2 ARESET = 1'b1;
      #1;
      n_cmp++;
      if (net_valid_out !== 1'b0 || rx_valid_out !== 1'b0 || drop_cnt !== 2'd0 ||
          net_data_out !== '0 || tx_ready_out !== 1'b1 || net_ready_out !== 1'b1) begin
         n_bad++;
         $display("FAIL async_reset: txv %b rxv %b cnt %0d data %h required 0 0 0 0",
                  net_valid_out, rx_valid_out, drop_cnt, net_data_out);
      end
      @(posedge ACLK); #1 ARESET = 1'b0;
      tx_dest_in = 6'd33; tx_payload_in = 10'h2A5; tx_valid_in = 1'b1;
      tx_q.push_back({6'd33, 10'h2A5});
      net_ready_in = 1'b1;
      step();
      tx_valid_in = 1'b0;
      budget = 5;
      while (tx_q.size() > 0 && budget > 0) begin
         if (net_valid_out) begin
            n_cmp++;
            if (net_data_out !== tx_q[0]) begin
               n_bad++;
               $display("FAIL post_reset_tx: got %h required %h", net_data_out, tx_q[0]);
            end
            void'(tx_q.pop_front());
         end
         step();
         budget--;
      end
      n_cmp++;
      if (tx_q.size() != 0 || net_valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_timeout: left %0d valid %b required 0 0", tx_q.size(), net_valid_out);
      end
      net_ready_in = 1'b0;
   endtask

   task automatic test_both_paths();
      int budget;
      do_reset();
      net_ready_in = 1'b1; rx_ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tx_dest_in = 6'd6; tx_payload_in = PAY_W'(i * 3 + 1); tx_valid_in = 1'b1;
         net_data_in = {6'd63, PAY_W'(i * 5)}; net_valid_in = 1'b1;
         if (tx_ready_out) tx_q.push_back({6'd6, PAY_W'(i * 3 + 1)});
         if (net_ready_out) rx_q.push_back({PAY_W'(i * 5), 1'b1});
         if (net_valid_out) begin
            n_cmp++;
            if (net_data_out !== tx_q[0]) begin
               n_bad++;
               $display("FAIL dual_tx: got %h required %h", net_data_out, tx_q[0]);
            end
            void'(tx_q.pop_front());
         end
         if (rx_valid_out) begin
            n_cmp++;
            if ({rx_payload_out, rx_bcast_out} !== rx_q[0]) begin
               n_bad++;
               $display("FAIL dual_rx: got %h/%b required %h", rx_payload_out, rx_bcast_out, rx_q[0]);
            end
            void'(rx_q.pop_front());
         end
         step();
      end
      tx_valid_in = 1'b0; net_valid_in = 1'b0;
      budget = 10;
      while ((tx_q.size() > 0 || rx_q.size() > 0) && budget > 0) begin
         if (net_valid_out && tx_q.size() > 0) begin
            n_cmp++;
            if (net_data_out !== tx_q[0]) begin
               n_bad++;
               $display("FAIL dual_tx_tail: got %h required %h", net_data_out, tx_q[0]);
            end
            void'(tx_q.pop_front());
         end
         if (rx_valid_out && rx_q.size() > 0) begin
            n_cmp++;
            if ({rx_payload_out, rx_bcast_out} !== rx_q[0]) begin
               n_bad++;
               $display("FAIL dual_rx_tail: got %h required %h", rx_payload_out, rx_q[0]);
            end
            void'(rx_q.pop_front());
         end
         step();
         budget--;
      end
      n_cmp++;
      if (tx_q.size() != 0 || rx_q.size() != 0 || net_valid_out !== 1'b0 || rx_valid_out !== 1'b0) begin
         n_bad++;
         $display("FAIL dual_timeout: tx %0d rx %0d txv %b rxv %b required all 0",
                  tx_q.size(), rx_q.size(), net_valid_out, rx_valid_out);
      end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_tx_full();
      test_rx_filter();
      test_drop();
      test_backpressure();
      test_reset_mid();
      test_both_paths();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gpu_net_iface.md
Name: gpu_net_iface

Overview:
- Parametrised network interface between a GPU node's control logic and the 16-bit NoC flit links.
- Packs {dest, payload} flits into a TX FIFO and drives them onto the link with valid/ready handshaking.
- Filters incoming flits by destination (unicast to GPU_ID, or broadcast) into an RX FIFO for the local consumer.
- Drops and counts flits addressed to other nodes. Neither FIFO ever loses an accepted flit.

Parameters:
GPU_ID, 6, this node's identifier; compared against the flit dest field
FLIT_W, 16, flit width on the network links
DEST_W, 6, dest field width; occupies flit[FLIT_W-1 -: DEST_W]; payload width PAY_W = FLIT_W-DEST_W
FIFO_DEPTH, 4, entries in each of TX and RX FIFO; power of two, >=2
BCAST_ID, {DEST_W{1'b1}}, dest value accepted by every node
CNT_W, 16, width of the drop counter

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
tx_dest_in  in  DEST_W  destination of flit to send
tx_payload_in  in  PAY_W  payload of flit to send
tx_valid_in  in  1  local send request
tx_ready_out  out  1  TX FIFO can accept (= !tx_full)
net_data_out  out  FLIT_W  flit to network, {dest, payload}
net_valid_out  out  1  net_data_out valid (= !tx_empty)
net_ready_in  in  1  network accepts flit
net_data_in  in  FLIT_W  flit from network
net_valid_in  in  1  net_data_in valid
net_ready_out  out  1  interface accepts flit (= !rx_full)
rx_payload_out  out  PAY_W  payload of head RX flit
rx_bcast_out  out  1  head RX flit was broadcast
rx_valid_out  out  1  RX FIFO non-empty
rx_ready_in  in  1  local consumer pops RX head
drop_cnt  out  CNT_W  count of accepted flits not for this node; saturating

Behaviour:
- Reset (async assert, sync release): both FIFOs empty; tx_ready_out=1, net_valid_out=0, net_ready_out=1, rx_valid_out=0; data outputs 0; drop_cnt=0.
- Reset mid-operation flushes all queued flits with no partial output.
- TX push: occurs when tx_valid_in && tx_ready_out; the stored flit is {tx_dest_in, tx_payload_in}.
- TX pop: occurs when net_valid_out && net_ready_in.
- Show-ahead FIFOs: the head is presented from storage, so a flit pushed in cycle N is visible on net_data_out in cycle N+1. There is no same-cycle bypass.
- net_data_out and net_valid_out hold stable until the pop handshake completes; the AXI-style valid/ready rule applies.
- RX accept: occurs when net_valid_in && net_ready_out. Let d = net_data_in[FLIT_W-1 -: DEST_W].
  - If d==GPU_ID or d==BCAST_ID: push {payload, d==BCAST_ID} into RX FIFO.
  - Otherwise: discard the flit and increment drop_cnt; it saturates at all-ones and does not wrap.
- net_ready_out depends only on the RX full flag (registered state), never on net_data_in. A full RX FIFO therefore back-pressures all flits, including non-matching ones.
- RX pop: occurs when rx_valid_out && rx_ready_in.
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: occupancy unchanged, both pointers advance.
  - Empty FIFO: pop impossible, push succeeds.
  - Full FIFO: push is blocked by ready=0, pop succeeds.
- Pointers are log2(FIFO_DEPTH)+1 bits with an extra wrap bit.
  - full = MSBs differ and LSBs equal.
  - empty = pointers equal.
  - Address wrap-around is natural modulo FIFO_DEPTH.
- tx_dest_in==GPU_ID is legal; the flit is sent on the network with no local loopback.
- Ordering is strictly FIFO per direction. TX and RX paths are fully independent and may both handshake in the same cycle.

Decomposition:
- gpu_net_pkg holds:
  - default FLIT_W/DEST_W/BCAST_ID constants;
  - the flit field position localparams (dest MSB/LSB, payload MSB/LSB);
  - a flit_t struct {dest, payload}.
- One sub-module, gpu_net_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty, and the same ACLK/ARESET.
  - It is instantiated twice: TX with WIDTH=FLIT_W, RX with WIDTH=PAY_W+1.

Test Plan:
- Reset, then push dest=7 payload=0x123 with net_ready_in=1 -> net_data_out=0x1D23 and net_valid_out=1 one cycle after push; valid drops after the handshake.
- net_ready_in=0, push 5 flits with FIFO_DEPTH=4 -> 4 accepted, tx_ready_out=0 on the 5th. Release ready -> the 4 flits exit in order and data stays stable while stalled.
- net_data_in=0x1ABC (dest 6) -> rx_payload_out=0x2BC, rx_bcast_out=0. net_data_in=0xFC01 (dest 63) -> rx_payload_out=0x001, rx_bcast_out=1.
- 3 flits with dest=5 -> not queued, drop_cnt=3. With CNT_W=2, 5 non-matching flits -> drop_cnt saturates at 3.
- rx_ready_in=0, send 4 matching flits -> net_ready_out=0 and a 5th non-matching flit is stalled with drop_cnt unchanged. One pop -> the 5th flit is accepted and dropped.
- Assert ARESET with 2 TX and 3 RX flits queued -> all valids 0 and drop_cnt=0 immediately (asynchronously); after release the first new push emerges correctly.
